load_buffer: RTL and testbench

Load-side memory stage directly downstream of the load/store queue. It accepts in-order address-unit issues (base, offset, type, ROB tag) and computes effective addresses. Loads are held in a small FIFO, performed one at a time through the memory controller, extended, and broadcast on the load CDB. Store addresses are forwarded to the ROB for commit-time writes. It also generates the `lbuffer_rdy` back-pressure the queue uses to gate load issue.

---
 rtl/load_buffer.sv | 171 +++++++++++++++++
 tb/tb_load_buffer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_buffer.sv
// rtl/load_buffer.sv - load-side memory stage: address generation, load FIFO, memory sequencing, CDB broadcast
module load_buffer #(
  parameter int DEPTH             = 4,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ROB_WIDTH         = 4,
  parameter int INST_TYPE_WIDTH   = 3,
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_LB  = 3'd0,
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_LH  = 3'd1,
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_LW  = 3'd2,
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_LBU = 3'd3,
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_LHU = 3'd4,
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_SB  = 3'd5,
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_SH  = 3'd6,
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_SW  = 3'd7
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         lsqueue_en_in,
  input  logic [INSTRUCTION_WIDTH-1:0] lsqueue_A_in,
  input  logic [INSTRUCTION_WIDTH-1:0] lsqueue_vj_in,
  input  logic [ROB_WIDTH-1:0]         lsqueue_dest_in,
  input  logic [INST_TYPE_WIDTH-1:0]   lsqueue_inst_type_in,
  output logic                         lbuffer_rdy_out,
  output logic                         mem_req_out,
  output logic [31:0]                  mem_addr_out,
  output logic [1:0]                   mem_size_out,
  input  logic                         mem_done_in,
  input  logic [31:0]                  mem_data_in,
  output logic                         cdb_en_out,
  output logic [ROB_WIDTH-1:0]         cdb_dest_out,
  output logic [31:0]                  cdb_value_out,
  input  logic                         rob_flush_in,
  output logic                         rob_addr_en_out,
  output logic [ROB_WIDTH-1:0]         rob_addr_dest_out,
  output logic [31:0]                  rob_addr_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t state, state_d;

  logic [31:0]                fifo_addr [DEPTH];
  logic [ROB_WIDTH-1:0]       fifo_dest [DEPTH];
  logic [INST_TYPE_WIDTH-1:0] fifo_type [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic [31:0] issue_addr;
  logic        is_load, is_store, accept, push;
  logic        issue, pop, req_clr;

  function automatic logic [1:0] size_of(input logic [INST_TYPE_WIDTH-1:0] t);
    if (t == TYPE_LB || t == TYPE_LBU) return 2'd0;
    if (t == TYPE_LH || t == TYPE_LHU) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] extend(input logic [INST_TYPE_WIDTH-1:0] t, input logic [31:0] d);
    if (t == TYPE_LB)  return {{24{d[7]}}, d[7:0]};
    if (t == TYPE_LBU) return {24'd0, d[7:0]};
    if (t == TYPE_LH)  return {{16{d[15]}}, d[15:0]};
    if (t == TYPE_LHU) return {16'd0, d[15:0]};
    return d;
  endfunction

  assign issue_addr = 32'(lsqueue_vj_in + lsqueue_A_in);
  assign is_load    = lsqueue_inst_type_in inside {TYPE_LB, TYPE_LH, TYPE_LW, TYPE_LBU, TYPE_LHU};
  assign is_store   = lsqueue_inst_type_in inside {TYPE_SB, TYPE_SH, TYPE_SW};
  assign accept     = rdy_in && lsqueue_en_in && !rob_flush_in;
  assign push       = accept && is_load;

  // Leaves room for the one issue the queue may already have in flight
  assign lbuffer_rdy_out = ({1'b0, count} + {{CNT_W{1'b0}}, lsqueue_en_in})
                           <= (CNT_W+1)'(DEPTH - 2);

  always_comb begin
    state_d = state;
    issue   = 1'b0;
    pop     = 1'b0;
    req_clr = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rob_flush_in && count != '0) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_done_in) begin
          req_clr = 1'b1;
          pop     = !rob_flush_in;
          state_d = S_IDLE;
        end else if (rob_flush_in) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_done_in) begin
          req_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Entry storage needs no reset; occupancy is tracked by head/tail/count
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_addr[tail] <= issue_addr;
      fifo_dest[tail] <= lsqueue_dest_in;
      fifo_type[tail] <= lsqueue_inst_type_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= S_IDLE;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      mem_req_out       <= 1'b0;
      mem_addr_out      <= '0;
      mem_size_out      <= '0;
      cdb_en_out        <= 1'b0;
      cdb_dest_out      <= '0;
      cdb_value_out     <= '0;
      rob_addr_en_out   <= 1'b0;
      rob_addr_dest_out <= '0;
      rob_addr_out      <= '0;
    end else if (rdy_in) begin
      state           <= state_d;
      cdb_en_out      <= pop;
      rob_addr_en_out <= accept && is_store;
      if (accept && is_store) begin
        rob_addr_dest_out <= lsqueue_dest_in;
        rob_addr_out      <= issue_addr;
      end
      if (issue) begin
        mem_req_out  <= 1'b1;
        mem_addr_out <= fifo_addr[head];
        mem_size_out <= size_of(fifo_type[head]);
      end else if (req_clr) begin
        mem_req_out <= 1'b0;
      end
      if (pop) begin
        cdb_dest_out  <= fifo_dest[head];
        cdb_value_out <= extend(fifo_type[head], mem_data_in);
      end
      if (rob_flush_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_load_buffer.sv
// tb/tb_load_buffer.sv - directed bench for load_buffer with a queue-based reference model
module tb_load_buffer;

  localparam int DEPTH = 4;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4;
  localparam logic [2:0] SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, lsqueue_en_in, mem_done_in, rob_flush_in;
  logic [31:0] lsqueue_A_in, lsqueue_vj_in, mem_data_in;
  logic [3:0]  lsqueue_dest_in;
  logic [2:0]  lsqueue_inst_type_in;
  logic        lbuffer_rdy_out, mem_req_out, cdb_en_out, rob_addr_en_out;
  logic [31:0] mem_addr_out, cdb_value_out, rob_addr_out;
  logic [1:0]  mem_size_out;
  logic [3:0]  cdb_dest_out, rob_addr_dest_out;

  load_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .lsqueue_en_in(lsqueue_en_in), .lsqueue_A_in(lsqueue_A_in), .lsqueue_vj_in(lsqueue_vj_in),
    .lsqueue_dest_in(lsqueue_dest_in), .lsqueue_inst_type_in(lsqueue_inst_type_in),
    .lbuffer_rdy_out(lbuffer_rdy_out), .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .mem_size_out(mem_size_out), .mem_done_in(mem_done_in), .mem_data_in(mem_data_in),
    .cdb_en_out(cdb_en_out), .cdb_dest_out(cdb_dest_out), .cdb_value_out(cdb_value_out),
    .rob_flush_in(rob_flush_in), .rob_addr_en_out(rob_addr_en_out),
    .rob_addr_dest_out(rob_addr_dest_out), .rob_addr_out(rob_addr_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending loads plus the expected output values
  typedef struct { logic [31:0] addr; logic [3:0] dest; logic [2:0] t; } ent_t;
  ent_t        m_q[$];
  logic        m_busy, m_drain, m_req, m_cdb_en, m_rob_en;
  logic [31:0] m_addr, m_cdb_val, m_rob_addr;
  logic [1:0]  m_size;
  logic [3:0]  m_cdb_dest, m_rob_dest;

  function automatic logic [1:0] model_size(input logic [2:0] t);
    if (t == LB || t == LBU) return 2'd0;
    if (t == LH || t == LHU) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] t, input logic [31:0] d);
    int v;
    case (t)
      LB:  begin v = int'(d % 256);   if (v >= 128)   v -= 256;   end
      LBU: v = int'(d % 256);
      LH:  begin v = int'(d % 65536); if (v >= 32768) v -= 65536; end
      LHU: v = int'(d % 65536);
      default: return d;
    endcase
    return 32'(v);
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_q.delete();
      m_busy = 0; m_drain = 0; m_req = 0; m_cdb_en = 0; m_rob_en = 0;
      m_addr = 0; m_size = 0; m_cdb_val = 0; m_cdb_dest = 0; m_rob_addr = 0; m_rob_dest = 0;
    end else if (rdy_in) begin
      m_cdb_en = 0;
      m_rob_en = 0;
      if (rob_flush_in) begin
        if ((m_busy || m_drain) && mem_done_in) begin
          m_req = 0; m_busy = 0; m_drain = 0;
        end else if (m_busy) begin
          m_busy = 0; m_drain = 1;
        end
        m_q.delete();
      end else begin
        int pre;
        pre = m_q.size();
        if (m_busy && mem_done_in) begin
          ent_t e;
          e = m_q.pop_front();
          m_cdb_en = 1; m_cdb_dest = e.dest; m_cdb_val = model_ext(e.t, mem_data_in);
          m_req = 0; m_busy = 0;
        end else if (m_drain && mem_done_in) begin
          m_req = 0; m_drain = 0;
        end else if (!m_busy && !m_drain && m_q.size() > 0) begin
          m_req = 1; m_addr = m_q[0].addr; m_size = model_size(m_q[0].t); m_busy = 1;
        end
        if (lsqueue_en_in) begin
          if (lsqueue_inst_type_in inside {LB, LH, LW, LBU, LHU}) begin
            ent_t n;
            checks++;
            if (pre >= DEPTH) begin
              fails++;
              $display("FAIL fifo_overflow: write with %0d entries held, limit %0d", pre, DEPTH - 1);
            end
            n.addr = lsqueue_vj_in + lsqueue_A_in; n.dest = lsqueue_dest_in; n.t = lsqueue_inst_type_in;
            m_q.push_back(n);
          end else begin
            m_rob_en = 1; m_rob_dest = lsqueue_dest_in; m_rob_addr = lsqueue_vj_in + lsqueue_A_in;
          end
        end
      end
    end
  end

  always @(negedge clk_in) begin
    #1;
    if (!rst_in) begin
      logic exp_rdy;
      exp_rdy = (m_q.size() + int'(lsqueue_en_in)) <= DEPTH - 2;
      chk("model_mem_req", 32'(mem_req_out), 32'(m_req));
      if (m_req) begin
        chk("model_mem_addr", mem_addr_out, m_addr);
        chk("model_mem_size", 32'(mem_size_out), 32'(m_size));
      end
      chk("model_cdb_en", 32'(cdb_en_out), 32'(m_cdb_en));
      if (m_cdb_en) begin
        chk("model_cdb_dest", 32'(cdb_dest_out), 32'(m_cdb_dest));
        chk("model_cdb_value", cdb_value_out, m_cdb_val);
      end
      chk("model_rob_en", 32'(rob_addr_en_out), 32'(m_rob_en));
      if (m_rob_en) begin
        chk("model_rob_dest", 32'(rob_addr_dest_out), 32'(m_rob_dest));
        chk("model_rob_addr", rob_addr_out, m_rob_addr);
      end
      chk("model_lbuffer_rdy", 32'(lbuffer_rdy_out), 32'(exp_rdy));
    end
  end

  task automatic issue(input logic [2:0] t, input logic [31:0] vj, input logic [31:0] a, input logic [3:0] d);
    @(negedge clk_in);
    lsqueue_en_in = 1; lsqueue_inst_type_in = t; lsqueue_vj_in = vj; lsqueue_A_in = a; lsqueue_dest_in = d;
    @(negedge clk_in);
    lsqueue_en_in = 0;
  endtask

  task automatic wait_req();
    int n = 0;
    #1;
    while (!mem_req_out && n < 50) begin
      @(negedge clk_in); #1; n++;
    end
    chk("mem_req_seen", 32'(mem_req_out), 32'd1);
  endtask

  task automatic mem_reply(input logic [31:0] data, input int delay, input logic [31:0] ea, input logic [1:0] es);
    wait_req();
    chk("mem_addr", mem_addr_out, ea);
    chk("mem_size", 32'(mem_size_out), 32'(es));
    repeat (delay) @(negedge clk_in);
    mem_done_in = 1; mem_data_in = data;
    @(negedge clk_in);
    mem_done_in = 0;
  endtask

  task automatic expect_cdb(input logic [3:0] d, input logic [31:0] v);
    int n = 0;
    #1;
    while (!cdb_en_out && n < 10) begin
      @(negedge clk_in); #1; n++;
    end
    chk("cdb_en", 32'(cdb_en_out), 32'd1);
    chk("cdb_dest", 32'(cdb_dest_out), 32'(d));
    chk("cdb_value", cdb_value_out, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1; rdy_in = 1; lsqueue_en_in = 0; lsqueue_A_in = 0; lsqueue_vj_in = 0;
    lsqueue_dest_in = 0; lsqueue_inst_type_in = LB; mem_done_in = 0; mem_data_in = 0; rob_flush_in = 0;
    #3;
    chk("reset_mem_req", 32'(mem_req_out), 32'd0);
    chk("reset_cdb_en", 32'(cdb_en_out), 32'd0);
    chk("reset_rob_en", 32'(rob_addr_en_out), 32'd0);
    chk("reset_mem_addr", mem_addr_out, 32'd0);
    chk("reset_lbuffer_rdy", 32'(lbuffer_rdy_out), 32'd1);
    repeat (2) @(negedge clk_in);
    rst_in = 0;

    // LW
    issue(LW, 32'h100, 32'h4, 4'd3);
    mem_reply(32'hDEADBEEF, 2, 32'h104, 2'd2);
    expect_cdb(4'd3, 32'hDEADBEEF);

    // Extensions
    issue(LB, 32'h10, 32'h1, 4'd1);
    mem_reply(32'h00000080, 1, 32'h11, 2'd0);
    expect_cdb(4'd1, 32'hFFFFFF80);
    issue(LBU, 32'h10, 32'h2, 4'd2);
    mem_reply(32'h55AA3380, 1, 32'h12, 2'd0);
    expect_cdb(4'd2, 32'h00000080);
    issue(LH, 32'h20, 32'h0, 4'd4);
    mem_reply(32'h00008001, 3, 32'h20, 2'd1);
    expect_cdb(4'd4, 32'hFFFF8001);
    issue(LHU, 32'h20, 32'h2, 4'd5);
    mem_reply(32'h00008001, 1, 32'h22, 2'd1);
    expect_cdb(4'd5, 32'h00008001);

    // Store
    issue(SW, 32'h2000, 32'hFFFFFFFC, 4'd7);
    #1;
    chk("store_rob_en", 32'(rob_addr_en_out), 32'd1);
    chk("store_rob_dest", 32'(rob_addr_dest_out), 32'd7);
    chk("store_rob_addr", rob_addr_out, 32'h1FFC);
    chk("store_no_req", 32'(mem_req_out), 32'd0);

    // Fill with done withheld
    issue(LW, 32'h300, 32'h0, 4'd8);
    issue(LHU, 32'h300, 32'h4, 4'd9);
    #1;
    chk("fill_rdy_two", 32'(lbuffer_rdy_out), 32'd1);
    @(negedge clk_in);
    lsqueue_en_in = 1; lsqueue_inst_type_in = LB; lsqueue_vj_in = 32'h300; lsqueue_A_in = 32'h7; lsqueue_dest_in = 4'd10;
    #1;
    chk("fill_rdy_in_flight", 32'(lbuffer_rdy_out), 32'd0);
    @(negedge clk_in);
    lsqueue_en_in = 0;
    #1;
    chk("fill_rdy_three", 32'(lbuffer_rdy_out), 32'd0);
    mem_reply(32'h12345678, 2, 32'h300, 2'd2);
    expect_cdb(4'd8, 32'h12345678);
    mem_reply(32'hFFFF7FFF, 1, 32'h304, 2'd1);
    expect_cdb(4'd9, 32'h00007FFF);
    mem_reply(32'h0000007F, 1, 32'h307, 2'd0);
    expect_cdb(4'd10, 32'h0000007F);
    @(negedge clk_in); #1;
    chk("fill_rdy_back", 32'(lbuffer_rdy_out), 32'd1);

    // Flush during WAIT with a same-cycle store that must be dropped
    issue(LW, 32'h400, 32'h0, 4'd11);
    issue(LW, 32'h404, 32'h0, 4'd12);
    wait_req();
    @(negedge clk_in);
    rob_flush_in = 1;
    lsqueue_en_in = 1; lsqueue_inst_type_in = SW; lsqueue_vj_in = 32'h500; lsqueue_A_in = 0; lsqueue_dest_in = 4'd13;
    @(negedge clk_in);
    rob_flush_in = 0; lsqueue_en_in = 0;
    #1;
    chk("flush_req_held", 32'(mem_req_out), 32'd1);
    chk("flush_store_dropped", 32'(rob_addr_en_out), 32'd0);
    repeat (2) @(negedge clk_in);
    mem_done_in = 1; mem_data_in = 32'hBADBAD00;
    @(negedge clk_in);
    mem_done_in = 0;
    #1;
    chk("drain_no_cdb", 32'(cdb_en_out), 32'd0);
    chk("drain_req_low", 32'(mem_req_out), 32'd0);
    @(negedge clk_in); #1;
    chk("drain_stays_idle", 32'(mem_req_out), 32'd0);
    issue(LW, 32'h600, 32'h8, 4'd14);
    mem_reply(32'hCAFEF00D, 1, 32'h608, 2'd2);
    expect_cdb(4'd14, 32'hCAFEF00D);

    // rdy_in low stretches a pending pulse
    issue(SB, 32'h700, 32'h3, 4'd2);
    rdy_in = 0;
    #1;
    chk("stall_rob_en_0", 32'(rob_addr_en_out), 32'd1);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk_in); #1;
      chk("stall_rob_en_held", 32'(rob_addr_en_out), 32'd1);
    end
    @(negedge clk_in);
    rdy_in = 1;
    @(negedge clk_in); #1;
    chk("stall_rob_en_cleared", 32'(rob_addr_en_out), 32'd0);

    // Asynchronous reset mid-WAIT
    issue(LW, 32'h800, 32'h0, 4'd6);
    wait_req();
    #2;
    rst_in = 1;
    #1;
    chk("areset_mem_req", 32'(mem_req_out), 32'd0);
    chk("areset_cdb_en", 32'(cdb_en_out), 32'd0);
    chk("areset_lbuffer_rdy", 32'(lbuffer_rdy_out), 32'd1);
    @(negedge clk_in);
    rst_in = 0;
    @(negedge clk_in); #1;
    chk("areset_idle", 32'(mem_req_out), 32'd0);
    issue(LH, 32'h900, 32'h2, 4'd15);
    mem_reply(32'h0000FFFE, 1, 32'h902, 2'd1);
    expect_cdb(4'd15, 32'hFFFFFFFE);

    repeat (3) @(negedge clk_in);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
